// File: rtl/obi_ext_slave_mem.sv
// OBI responder memory: byte-lane writes, fixed-latency in-order responses, bounded outstanding count.
// Optional random grant stalls when OBI_EXT_SLAVE_MEM_STALL_EN is defined.
package obi_ext_slave_mem_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

module obi_ext_slave_mem
  import obi_ext_slave_mem_pkg::*;
#(
  parameter int unsigned NUM_WORDS       = 1024,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  obi_req_t                               slave_req_i,
  output obi_resp_t                              slave_resp_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

  localparam int unsigned AW = $clog2(NUM_WORDS);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  generate
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > LATENCY) begin : g_cfg_outstanding_err
      $error("obi_ext_slave_mem: MAX_OUTSTANDING must be in 1..LATENCY");
    end
    if (LATENCY < 1 || LATENCY > 8) begin : g_cfg_latency_err
      $error("obi_ext_slave_mem: LATENCY must be in 1..8");
    end
    if (NUM_WORDS < 2 || (NUM_WORDS & (NUM_WORDS - 1)) != 0 || AW > 30) begin : g_cfg_depth_err
      $error("obi_ext_slave_mem: NUM_WORDS must be a power of two >= 2");
    end
  endgenerate

  logic [AW-1:0]   word_idx;
  logic            stall;
  logic            gnt;
  logic            accept;
  logic            rvalid;
  logic [31:0]     rd_word;
  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic [LATENCY-1:0] pipe_valid_q, pipe_valid_d;
  logic [LATENCY-1:0] pipe_we_q, pipe_we_d;
  logic [31:0]     pipe_data_q [LATENCY];

  // Upper address bits alias onto the same words; byte offset is ignored.
  assign word_idx = slave_req_i.addr[AW+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{slave_req_i.addr[31:AW+2], slave_req_i.addr[1:0]};

`ifdef OBI_EXT_SLAVE_MEM_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  assign gnt    = slave_req_i.req & ~rst_i & (outstanding_q < MAX_OUT) & ~stall;
  assign accept = slave_req_i.req & gnt;
  assign rvalid = pipe_valid_q[LATENCY-1];

  // One narrow array per byte lane so each lane's write enable stays independent.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [NUM_WORDS];

      always_ff @(posedge clk_i) begin
        if (accept && slave_req_i.we && slave_req_i.be[gi]) begin
          lane_mem[word_idx] <= slave_req_i.wdata[8*gi +: 8];
        end
      end

      assign rd_word[8*gi +: 8] = lane_mem[word_idx];
    end
  endgenerate

  always_comb begin
    pipe_valid_d    = '0;
    pipe_we_d       = '0;
    pipe_valid_d[0] = accept;
    pipe_we_d[0]    = slave_req_i.we;
    for (int s = 1; s < LATENCY; s++) begin
      pipe_valid_d[s] = pipe_valid_q[s-1];
      pipe_we_d[s]    = pipe_we_q[s-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pipe_valid_q <= '0;
      pipe_we_q    <= '0;
    end else begin
      pipe_valid_q <= pipe_valid_d;
      pipe_we_q    <= pipe_we_d;
    end
  end

  // Data needs no reset: the output is gated by the stage valid bit.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      pipe_data_q[0] <= slave_req_i.we ? 32'h0 : rd_word;
    end
    for (int s = 1; s < LATENCY; s++) begin
      pipe_data_q[s] <= pipe_data_q[s-1];
    end
  end

  always_comb begin
    outstanding_d = outstanding_q;
    case ({accept, rvalid})
      2'b10:   outstanding_d = outstanding_q + OW'(1);
      2'b01:   outstanding_d = outstanding_q - OW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
    end else begin
      outstanding_q <= outstanding_d;
    end
  end

  assign outstanding_o       = outstanding_q;
  assign slave_resp_o.gnt    = gnt;
  assign slave_resp_o.rvalid = rvalid;
  assign slave_resp_o.rdata  = (rvalid && !pipe_we_q[LATENCY-1]) ? pipe_data_q[LATENCY-1] : 32'h0;

endmodule

// File: tb/tb_obi_ext_slave_mem.sv
// Directed bench: default configuration via a cycle table, plus a LATENCY=1/MAX_OUTSTANDING=1 instance.
module tb_obi_ext_slave_mem;
  import obi_ext_slave_mem_pkg::*;

  logic      clk;
  logic      rst;
  obi_req_t  req0, req1;
  obi_resp_t resp0, resp1;
  logic [1:0] outs0;
  logic [0:0] outs1;

  int checks = 0;
  int errors = 0;

  obi_ext_slave_mem #(.NUM_WORDS(1024), .LATENCY(2), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk), .rst_i(rst), .slave_req_i(req0), .slave_resp_o(resp0), .outstanding_o(outs0)
  );

  obi_ext_slave_mem #(.NUM_WORDS(16), .LATENCY(1), .MAX_OUTSTANDING(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .slave_req_i(req1), .slave_resp_o(resp1), .outstanding_o(outs1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  outs;
  } vec_t;

  vec_t vecs [25];

  function automatic obi_req_t mk(logic r, logic w, logic [3:0] be, logic [31:0] a, logic [31:0] d);
    obi_req_t q;
    q.req = r; q.we = w; q.be = be; q.addr = a; q.wdata = d;
    return q;
  endfunction

  function automatic vec_t mv(logic r, logic w, logic [3:0] be, logic [31:0] a, logic [31:0] d,
                              logic g, logic v, logic [31:0] rd, logic [1:0] o);
    vec_t x;
    x.req = r; x.we = w; x.be = be; x.addr = a; x.wdata = d;
    x.gnt = g; x.rvalid = v; x.rdata = rd; x.outs = o;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk0(input string tag, input logic g, input logic v, input logic [31:0] rd, input logic [1:0] o);
    @(negedge clk);
    chk({tag, " gnt"}, 32'(resp0.gnt), 32'(g));
    chk({tag, " rvalid"}, 32'(resp0.rvalid), 32'(v));
    chk({tag, " rdata"}, resp0.rdata, rd);
    chk({tag, " outstanding"}, 32'(outs0), 32'(o));
    $display("%s: gnt=%0b rvalid=%0b rdata=%h outstanding=%0d", tag, resp0.gnt, resp0.rvalid, resp0.rdata, outs0);
  endtask

  initial begin
    int gnt_cnt;
    int rv_cnt;

    // write 0x10, then read it back
    vecs[0]  = mv(1, 1, 4'hF, 32'h10,   32'hDEADBEEF, 1, 0, 32'h0,        0);
    vecs[1]  = mv(1, 0, 4'hF, 32'h10,   32'h0,        1, 0, 32'h0,        1);
    vecs[2]  = mv(0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 32'h0,        2);
    vecs[3]  = mv(0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 32'hDEADBEEF, 1);
    vecs[4]  = mv(0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 32'h0,        0);
    // partial write over a preloaded word; the read is held through one backpressure cycle
    vecs[5]  = mv(1, 1, 4'hF, 32'h20,   32'h11223344, 1, 0, 32'h0,        0);
    vecs[6]  = mv(1, 1, 4'h5, 32'h20,   32'hAABBCCDD, 1, 0, 32'h0,        1);
    vecs[7]  = mv(1, 0, 4'hF, 32'h20,   32'h0,        0, 1, 32'h0,        2);
    vecs[8]  = mv(1, 0, 4'hF, 32'h20,   32'h0,        1, 1, 32'h0,        1);
    vecs[9]  = mv(0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 32'h0,        1);
    vecs[10] = mv(0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 32'h11BB33DD, 1);
    vecs[11] = mv(0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 32'h0,        0);
    // aliasing: 0x1004 maps to the same word as 0x4
    vecs[12] = mv(1, 1, 4'hF, 32'h4,    32'h5A5A5A5A, 1, 0, 32'h0,        0);
    vecs[13] = mv(1, 0, 4'hF, 32'h1004, 32'h0,        1, 0, 32'h0,        1);
    vecs[14] = mv(0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 32'h0,        2);
    vecs[15] = mv(0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 32'h5A5A5A5A, 1);
    vecs[16] = mv(0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 32'h0,        0);
    // four reads with req held: accepts in cycles 0,1,3,4 of this group
    vecs[17] = mv(1, 0, 4'hF, 32'h10,   32'h0,        1, 0, 32'h0,        0);
    vecs[18] = mv(1, 0, 4'hF, 32'h20,   32'h0,        1, 0, 32'h0,        1);
    vecs[19] = mv(1, 0, 4'hF, 32'h4,    32'h0,        0, 1, 32'hDEADBEEF, 2);
    vecs[20] = mv(1, 0, 4'hF, 32'h4,    32'h0,        1, 1, 32'h11BB33DD, 1);
    vecs[21] = mv(1, 0, 4'hF, 32'h10,   32'h0,        1, 0, 32'h0,        1);
    vecs[22] = mv(0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 32'h5A5A5A5A, 2);
    vecs[23] = mv(0, 0, 4'h0, 32'h0,    32'h0,        0, 1, 32'hDEADBEEF, 1);
    vecs[24] = mv(0, 0, 4'h0, 32'h0,    32'h0,        0, 0, 32'h0,        0);

    rst  = 1'b1;
    req0 = mk(0, 0, 4'h0, 32'h0, 32'h0);
    req1 = mk(0, 0, 4'h0, 32'h0, 32'h0);
    next_cycle();
    req0 = mk(1, 0, 4'hF, 32'h10, 32'h0);
    chk0("reset", 0, 0, 32'h0, 0);
    next_cycle();
    rst  = 1'b0;

    for (int i = 0; i < 25; i++) begin
      req0 = mk(vecs[i].req, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata);
      chk0($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].outs);
      next_cycle();
    end

    // reset one cycle after two reads are accepted
    req0 = mk(1, 0, 4'hF, 32'h10, 32'h0);
    @(negedge clk); chk("midrst acceptA gnt", 32'(resp0.gnt), 32'd1);
    next_cycle();
    req0 = mk(1, 0, 4'hF, 32'h20, 32'h0);
    @(negedge clk); chk("midrst acceptB gnt", 32'(resp0.gnt), 32'd1);
    next_cycle();
    rst  = 1'b1;
    req0 = mk(1, 0, 4'hF, 32'h4, 32'h0);
    @(negedge clk); chk("midrst gnt during reset", 32'(resp0.gnt), 32'd0);
    next_cycle();
    chk0("midrst held", 0, 0, 32'h0, 0);
    next_cycle();
    rst  = 1'b0;
    req0 = mk(0, 0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk0($sformatf("postrst idle%0d", i), 0, 0, 32'h0, 0);
      next_cycle();
    end
    req0 = mk(1, 0, 4'hF, 32'h10, 32'h0);
    chk0("postrst read", 1, 0, 32'h0, 0);
    next_cycle();
    req0 = mk(0, 0, 4'h0, 32'h0, 32'h0);
    chk0("postrst wait", 0, 0, 32'h0, 1);
    next_cycle();
    chk0("postrst resp", 0, 1, 32'hDEADBEEF, 1);
    next_cycle();
    chk0("postrst done", 0, 0, 32'h0, 0);
    next_cycle();

    // LATENCY=1, MAX_OUTSTANDING=1: accept and retire coincide
    req1 = mk(1, 1, 4'hF, 32'h8, 32'h12345678);
    @(negedge clk);
    chk("l1 write gnt", 32'(resp1.gnt), 32'd1);
    chk("l1 write outstanding", 32'(outs1), 32'd0);
    next_cycle();
    req1 = mk(0, 0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    chk("l1 write rvalid", 32'(resp1.rvalid), 32'd1);
    chk("l1 write rdata", resp1.rdata, 32'h0);
    chk("l1 write outstanding1", 32'(outs1), 32'd1);
    next_cycle();
    gnt_cnt = 0;
    rv_cnt  = 0;
    for (int k = 0; k < 10; k++) begin
      req1 = (k < 8) ? mk(1, 0, 4'hF, 32'h8, 32'h0) : mk(0, 0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      if (resp1.gnt) gnt_cnt++;
      if (resp1.rvalid) rv_cnt++;
      chk($sformatf("l1 rd%0d gnt", k), 32'(resp1.gnt), (k < 8 && k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("l1 rd%0d outstanding", k), 32'(outs1), (k < 9 && k % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("l1 rd%0d rvalid", k), 32'(resp1.rvalid), (k < 9 && k % 2 == 1) ? 32'd1 : 32'd0);
      chk($sformatf("l1 rd%0d rdata", k), resp1.rdata, (k < 9 && k % 2 == 1) ? 32'h12345678 : 32'h0);
      $display("l1 rd%0d: gnt=%0b rvalid=%0b rdata=%h outstanding=%0d", k, resp1.gnt, resp1.rvalid, resp1.rdata, outs1);
      next_cycle();
    end
    chk("l1 grant count", 32'(gnt_cnt), 32'd4);
    chk("l1 rvalid count", 32'(rv_cnt), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
